// File: rtl/expr_eval.sv
// rtl/expr_eval.sv - single-digit +/* expression evaluator; EXPR_EVAL_OVF_EN enables sticky overflow detection
module expr_eval #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         clr,
   input  logic [7:0]   in,
   input  logic         in_valid,
   output logic [W-1:0] result,
   output logic         res_valid,
   output logic         err,
   output logic         ovf
);

   typedef enum logic [2:0] {S_START, S_NUM, S_OP_ADD, S_OP_MUL, S_ERR} state_t;

   localparam logic [7:0] CH_ADD = 8'h2B;
   localparam logic [7:0] CH_MUL = 8'h2A;

   state_t       state, state_n;
   logic [W-1:0] sum, sum_n, term, term_n;
   logic [3:0]   d;
   logic         is_digit, is_add, is_mul, load_result;

   // ASCII digits are 0x30..0x39, so the low nibble is the digit value
   assign d        = in[3:0];
   assign is_digit = (in >= 8'h30) && (in <= 8'h39);
   assign is_add   = (in == CH_ADD);
   assign is_mul   = (in == CH_MUL);

   always_comb begin
      state_n = state;
      sum_n   = sum;
      term_n  = term;
      if (in_valid) begin
         case (state)
            S_START: begin
               if (is_digit) begin
                  term_n  = W'(d);
                  sum_n   = '0;
                  state_n = S_NUM;
               end else begin
                  state_n = S_ERR;
               end
            end
            S_NUM: begin
               if (is_add) begin
                  sum_n   = sum + term;
                  state_n = S_OP_ADD;
               end else if (is_mul) begin
                  state_n = S_OP_MUL;
               end else begin
                  state_n = S_ERR;
               end
            end
            S_OP_ADD: begin
               if (is_digit) begin
                  term_n  = W'(d);
                  state_n = S_NUM;
               end else begin
                  state_n = S_ERR;
               end
            end
            S_OP_MUL: begin
               if (is_digit) begin
                  term_n  = term * W'(d);
                  state_n = S_NUM;
               end else begin
                  state_n = S_ERR;
               end
            end
            default: state_n = S_ERR;
         endcase
      end
   end

   // NUM never loops to itself, so any accepted step landing in NUM is an entry
   assign load_result = in_valid && (state != S_NUM) && (state_n == S_NUM);

   always_ff @(posedge clk) begin
      if (clr) begin
         state  <= S_START;
         sum    <= '0;
         term   <= '0;
         result <= '0;
      end else begin
         state <= state_n;
         sum   <= sum_n;
         term  <= term_n;
         if (load_result)
            result <= sum_n + term_n;
      end
   end

   assign res_valid = (state == S_NUM);
   assign err       = (state == S_ERR);

`ifdef EXPR_EVAL_OVF_EN
   logic [W:0]   add_full, res_full;
   logic [W+3:0] mul_full;
   logic         ovf_hit, ovf_q;

   assign add_full = {1'b0, sum} + {1'b0, term};
   assign res_full = {1'b0, sum_n} + {1'b0, term_n};
   assign mul_full = {4'b0, term} * {{W{1'b0}}, d};

   assign ovf_hit = in_valid &&
                    (((state == S_NUM) && is_add && add_full[W]) ||
                     ((state == S_OP_MUL) && is_digit && (|mul_full[W+3:W])) ||
                     (load_result && res_full[W]));

   always_ff @(posedge clk) begin
      if (clr)
         ovf_q <= 1'b0;
      else if (ovf_hit)
         ovf_q <= 1'b1;
   end

   assign ovf = ovf_q;
`else
   assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_expr_eval.sv
// tb/tb_expr_eval.sv - scoreboard bench for expr_eval (W=8) against a string-level reference model
module tb_expr_eval;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         clr = 1'b0;
   logic [7:0]   in = 8'h00;
   logic         in_valid = 1'b0;
   logic [W-1:0] result;
   logic         res_valid, err, ovf;

   expr_eval #(.W(W)) dut (
      .clk(clk), .clr(clr), .in(in), .in_valid(in_valid),
      .result(result), .res_valid(res_valid), .err(err), .ovf(ovf)
   );

   always #5 clk = ~clk;

   typedef struct {
      int res;
      int rv;
      int er;
      int ov;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad = 0;

   // reference model: the legal characters accepted since reset, re-evaluated from scratch
   byte  acc[$];
   bit   m_err;
   int   m_res;
   bit   m_ovf;

   function automatic bit is_dig(byte c);
      return (c >= "0") && (c <= "9");
   endfunction

   task automatic evaluate();
      int s, t, p;
      s = 0;
      t = acc[0] - "0";
      for (int i = 1; i + 1 < acc.size(); i += 2) begin
         if (acc[i] == "*") begin
            p = t * (acc[i+1] - "0");
            if (p > 255) m_ovf = 1;
            t = p % 256;
         end else begin
            if (s + t > 255) m_ovf = 1;
            s = (s + t) % 256;
            t = acc[i+1] - "0";
         end
         if (s + t > 255) m_ovf = 1;
      end
      m_res = (s + t) % 256;
   endtask

   task automatic model_step(input logic c, input logic v, input byte ch, output exp_t e);
      bit legal;
      if (c) begin
         acc.delete();
         m_err = 0;
         m_res = 0;
         m_ovf = 0;
      end else if (v && !m_err) begin
         if (acc.size() % 2 == 0) legal = is_dig(ch);
         else legal = (ch == "+") || (ch == "*");
         if (!legal) begin
            m_err = 1;
         end else begin
            acc.push_back(ch);
            if (is_dig(ch)) evaluate();
         end
      end
      e.res = m_res;
      e.rv  = (!m_err && (acc.size() % 2 == 1)) ? 1 : 0;
      e.er  = m_err ? 1 : 0;
`ifdef EXPR_EVAL_OVF_EN
      e.ov  = m_ovf ? 1 : 0;
`else
      e.ov  = 0;
`endif
   endtask

   task automatic cycle(input logic c, input logic v, input byte ch);
      exp_t e;
      @(negedge clk);
      #1;
      clr      = c;
      in_valid = v;
      in       = ch;
      model_step(c, v, ch, e);
      q.push_back(e);
      @(posedge clk);
   endtask

   task automatic send(input byte ch, input int gap);
      cycle(1'b0, 1'b1, ch);
      for (int g = 0; g < gap; g++)
         cycle(1'b0, 1'b0, byte'($urandom_range(0, 255)));
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d at t=%0t", name, got, want, $time);
      end
   endtask

   // monitor: every driven cycle produces one expected output set, checked mid-cycle
   always @(negedge clk) begin
      exp_t e;
      if (q.size() > 0) begin
         e = q.pop_front();
         chk("result", 32'(result), e.res);
         chk("res_valid", 32'(res_valid), e.rv);
         chk("err", 32'(err), e.er);
         chk("ovf", 32'(ovf), e.ov);
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      byte ch;
      int  r;
      cycle(1'b1, 1'b0, 8'h00);

      send("1", 0); send("+", 0); send("2", 0); send("*", 0); send("3", 0);

      cycle(1'b1, 1'b0, 8'h00);
      send("2", 2); send("*", 2); send("3", 2); send("+", 2);
      send("4", 2); send("*", 2); send("5", 2);

      cycle(1'b1, 1'b0, 8'h00);
      send("3", 0); send("+", 0); send("*", 0); send("4", 0);
      cycle(1'b1, 1'b0, 8'h00);
      cycle(1'b0, 1'b0, 8'h00);

      send("a", 0);
      cycle(1'b1, 1'b0, 8'h00);
      send("1", 0); send("2", 0);
      cycle(1'b1, 1'b0, 8'h00);
      send("+", 0);
      cycle(1'b1, 1'b0, 8'h00);
      send("/", 0);
      cycle(1'b1, 1'b0, 8'h00);
      send(":", 0);
      cycle(1'b1, 1'b0, 8'h00);
      send("0", 0); send("*", 0); send("9", 0);

      cycle(1'b1, 1'b0, 8'h00);
      send("9", 0); send("*", 0); send("9", 0); send("*", 0); send("9", 0);

      cycle(1'b1, 1'b1, "5");
      send("5", 0);

      for (int n = 0; n < 600; n++) begin
         r = $urandom_range(0, 99);
         if (r < 3) begin
            cycle(1'b1, r[0], byte'($urandom_range(0, 255)));
         end else if (r < 25) begin
            cycle(1'b0, 1'b0, byte'($urandom_range(0, 255)));
         end else begin
            if ($urandom_range(0, 99) < 4)
               ch = byte'($urandom_range(0, 255));
            else if (acc.size() % 2 == 0)
               ch = byte'("0" + $urandom_range(0, 9));
            else
               ch = ($urandom_range(0, 1) == 1) ? "+" : "*";
            cycle(1'b0, 1'b1, ch);
         end
      end

      @(negedge clk);
      #2;
      chk("queue_drained", 32'(q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
